// File: rtl/pe_v3_vec.sv
// Vector systolic PE: N lanes share one broadcast B operand, 2-stage multiply/add,
// chain (c_out = a*b + c_in) or output-stationary local accumulation with drain.

module pe_v3_lane #(
  parameter int W        = 16,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         chain_beat,
  input  logic         local_beat,
  input  logic         clr,
  input  logic         fire,
  output logic [W-1:0] c_out,
  output logic         sat_flag
);
  logic [2*W-1:0] p_s1;
  logic [W-1:0]   c_s1, acc;
  logic [2*W:0]   sum_chain, sum_acc, p_ext;
  logic [W:0]     r_chain, r_acc, r_p;

  // Returns {overflow, result}; overflow means discarded high bits were nonzero.
  function automatic logic [W:0] sat_fn(input logic [2*W:0] x);
    logic         ovf;
    logic [W-1:0] r;
    ovf = |x[2*W:W];
    r   = (SATURATE != 0 && ovf) ? {W{1'b1}} : x[W-1:0];
    return {ovf, r};
  endfunction

  always_comb begin
    p_ext     = {1'b0, p_s1};
    sum_chain = p_ext + {{(W+1){1'b0}}, c_s1};
    sum_acc   = p_ext + {{(W+1){1'b0}}, acc};
    r_chain   = sat_fn(sum_chain);
    r_acc     = sat_fn(sum_acc);
    r_p       = sat_fn(p_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1     <= '0;
      c_s1     <= '0;
      acc      <= '0;
      c_out    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (ld) begin
        p_s1 <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        c_s1 <= c;
      end
      if (chain_beat) begin
        c_out    <= r_chain[W-1:0];
        sat_flag <= sat_flag | r_chain[W];
      end else if (local_beat) begin
        // A drain colliding with a local beat emits the old sum and restarts from p.
        if (fire) begin
          c_out <= acc;
          acc   <= r_p[W-1:0];
        end else begin
          acc <= clr ? r_p[W-1:0] : r_acc[W-1:0];
        end
        if (clr) sat_flag <= (fire | clr) ? r_p[W] : r_acc[W];
        else     sat_flag <= sat_flag | (fire ? r_p[W] : r_acc[W]);
      end else if (fire) begin
        c_out <= acc;
        acc   <= '0;
      end
    end
  end
endmodule

module pe_v3_vec #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 2,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [VECTOR*REG_WIDTH-1:0] a_in,
  input  logic [REG_WIDTH-1:0]        b_in,
  input  logic [VECTOR*REG_WIDTH-1:0] c_in,
  input  logic                        mode,
  input  logic                        acc_clr,
  input  logic                        drain,
  output logic [VECTOR*REG_WIDTH-1:0] a_out,
  output logic [REG_WIDTH-1:0]        b_out,
  output logic                        ab_valid,
  output logic [VECTOR*REG_WIDTH-1:0] c_out,
  output logic                        out_valid,
  output logic [VECTOR-1:0]           sat_flag
);
  typedef struct packed {
    logic vld;
    logic mode;
    logic clr;
  } s1_ctrl_t;

  s1_ctrl_t s1;
  logic     drain_pend, chain_beat, local_beat, fire;

  // A chain result owns c_out this edge; a pending drain waits for a free edge.
  always_comb begin
    chain_beat = s1.vld & ~s1.mode;
    local_beat = s1.vld &  s1.mode;
    fire       = drain_pend & ~chain_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= '0;
      b_out      <= '0;
      s1         <= '0;
      out_valid  <= 1'b0;
      drain_pend <= 1'b0;
    end else begin
      a_out      <= a_in;
      b_out      <= b_in;
      s1         <= '{vld: in_valid, mode: mode, clr: acc_clr};
      out_valid  <= chain_beat | fire;
      drain_pend <= fire ? 1'b0 : (drain_pend | drain);
    end
  end

  assign ab_valid = s1.vld;

  for (genvar k = 0; k < VECTOR; k++) begin : g_lane
    pe_v3_lane #(.W(REG_WIDTH), .SATURATE(SATURATE)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (in_valid),
      .a         (a_in[k*REG_WIDTH +: REG_WIDTH]),
      .b         (b_in),
      .c         (c_in[k*REG_WIDTH +: REG_WIDTH]),
      .chain_beat(chain_beat),
      .local_beat(local_beat),
      .clr       (s1.clr),
      .fire      (fire),
      .c_out     (c_out[k*REG_WIDTH +: REG_WIDTH]),
      .sat_flag  (sat_flag[k])
    );
  end
endmodule

// File: tb/tb_pe_v3_vec.sv
// Directed scoreboard bench: saturating and wrapping instances share all stimulus.

module tb_pe_v3_vec;
  localparam int W = 16;
  localparam int V = 2;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, mode, acc_clr, drain;
  logic [V*W-1:0] a_in, c_in;
  logic [W-1:0]   b_in;
  logic [V*W-1:0] aout_s, aout_w, c_s, c_w;
  logic [W-1:0]   bout_s, bout_w;
  logic           abv_s, abv_w, ov_s, ov_w;
  logic [V-1:0]   flag_s, flag_w;

  typedef struct {
    logic [31:0] cs;
    logic [31:0] cw;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_v3_vec #(.REG_WIDTH(W), .VECTOR(V), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .mode(mode), .acc_clr(acc_clr), .drain(drain),
    .a_out(aout_s), .b_out(bout_s), .ab_valid(abv_s), .c_out(c_s),
    .out_valid(ov_s), .sat_flag(flag_s));

  pe_v3_vec #(.REG_WIDTH(W), .VECTOR(V), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .mode(mode), .acc_clr(acc_clr), .drain(drain),
    .a_out(aout_w), .b_out(bout_w), .ab_valid(abv_w), .c_out(c_w),
    .out_valid(ov_w), .sat_flag(flag_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic clr, input logic dr,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] b,
                       input logic [15:0] c0, input logic [15:0] c1);
    in_valid = v; mode = m; acc_clr = clr; drain = dr;
    a_in = {a1, a0}; b_in = b; c_in = {c1, c0};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic push(input int s0, input int s1, input int w0, input int w1);
    exp_t e;
    e.cs = {16'(s1), 16'(s0)};
    e.cw = {16'(w1), 16'(w0)};
    sb.push_back(e);
  endtask

  // One clock; any out_valid must match the oldest scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("ov_agree", 32'(ov_w), 32'(ov_s));
    if (ov_s) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(ov_s), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("c_out_sat", c_s, e.cs);
        chk("c_out_wrap", c_w, e.cw);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_c_out", c_s, 32'd0);
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_a_out", aout_s, 32'd0);
    chk("rst_ab_valid", 32'(abv_s), 32'd0);
    chk("rst_sat_flag", 32'(flag_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // chain: 3*4+10, 5*4+20
    drive(1, 0, 0, 0, 3, 5, 4, 10, 20);
    push(22, 40, 22, 40);
    tick();
    idle();
    chk("fwd_ab_valid", 32'(abv_s), 32'd1);
    chk("fwd_a_out", aout_s, {16'd5, 16'd3});
    chk("fwd_b_out", 32'(bout_s), 32'd4);
    chk("chain_not_early", 32'(sb.size()), 32'd1);
    tick();
    chk("chain_lat2", 32'(sb.size()), 32'd0);
    chk("fwd_ab_valid_drop", 32'(abv_s), 32'd0);

    // overflow: 300*300 = 90000 -> 65535 saturated, 24464 wrapped
    drive(1, 0, 0, 0, 300, 1, 300, 0, 0);
    push(65535, 300, 24464, 300);
    tick();
    idle();
    tick();
    chk("sat_flag_sat", 32'(flag_s), 32'd1);
    chk("sat_flag_wrap", 32'(flag_w), 32'd1);
    repeat (10) tick();
    chk("sat_flag_sticky", 32'(flag_s), 32'd1);
    chk("sat_flag_sticky_w", 32'(flag_w), 32'd1);

    // local accumulate: {4,6} + {5,5}
    drive(1, 1, 1, 0, 2, 3, 2, 0, 0);
    tick();
    drive(1, 1, 0, 0, 1, 1, 5, 0, 0);
    tick();
    idle();
    tick();
    chk("clr_clears_flag", 32'(flag_s), 32'd0);
    chk("clr_clears_flag_w", 32'(flag_w), 32'd0);
    chk("local_no_output", 32'(sb.size()), 32'd0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(9, 11, 9, 11);
    tick();
    idle();
    chk("drain_not_early", 32'(sb.size()), 32'd1);
    tick();
    chk("drain_emitted", 32'(sb.size()), 32'd0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("drain2_emitted", 32'(sb.size()), 32'd0);

    // chain beat and pending drain collide: chain first, drain next edge
    drive(1, 1, 1, 0, 2, 2, 3, 0, 0);
    tick();
    idle();
    tick();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0);
    push(1, 1, 1, 1);
    push(6, 6, 6, 6);
    tick();
    idle();
    tick();
    chk("collide_chain_first", 32'(sb.size()), 32'd1);
    tick();
    chk("collide_drain_next", 32'(sb.size()), 32'd0);

    // drain with a clr=0 local beat: old acc out, acc restarts at {6,14}
    drive(1, 1, 1, 0, 4, 4, 1, 0, 0);
    tick();
    idle();
    tick();
    drive(1, 1, 0, 1, 3, 7, 2, 0, 0);
    push(4, 4, 4, 4);
    tick();
    idle();
    tick();
    chk("collide_local_old_acc", 32'(sb.size()), 32'd0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(6, 14, 6, 14);
    tick();
    idle();
    tick();
    chk("collide_local_new_acc", 32'(sb.size()), 32'd0);

    // back-to-back mixed-mode stream, then reset with work in flight
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], i == 1, 0, 16'(i), 16'(i + 1), 16'(i + 2), 16'd100, 16'd200);
      if (!i[0]) push(i * (i + 2) + 100, (i + 1) * (i + 2) + 200,
                      i * (i + 2) + 100, (i + 1) * (i + 2) + 200);
      tick();
    end
    drive(1, 0, 0, 1, 9, 9, 9, 1, 1);
    tick();
    chk("stream_all_out", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_c_out", c_s, 32'd0);
    chk("async_rst_a_out", aout_s, 32'd0);
    chk("async_rst_b_out", 32'(bout_s), 32'd0);
    chk("async_rst_ab_valid", 32'(abv_s), 32'd0);
    chk("async_rst_out_valid", 32'(ov_s), 32'd0);
    chk("async_rst_c_out_w", c_w, 32'd0);
    idle();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0);
    tick();
    idle();
    tick();
    tick();
    chk("post_rst_acc_lost", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
